// File: rtl/rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared types and helpers for the round-robin arbiter family.
//   rr_state_e : arbiter control state (IDLE, GRANT)
//   wrap_inc   : modulo increment with an explicit compare-to-last wrap, so
//                requester counts that are not a power of two wrap correctly
// -----------------------------------------------------------------------------
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    // Next index after idx in a ring of num entries.
    function automatic int wrap_inc(input int idx, input int num);
        int res;
        if (idx >= num - 32'sd1) begin
            res = 32'sd0;
        end else begin
            res = idx + 32'sd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick. Scans req starting at ptr, wrapping past
// NUM_REQ-1 back to 0, and reports the first set bit.
// Ports:
//   req     [NUM_REQ]  request vector
//   ptr     [IDX_W]    highest-priority index
//   win     [NUM_REQ]  one-hot winner, all-zero when no request
//   win_idx [IDX_W]    binary index of the winner (0 when no request)
//   any     [1]        at least one request present
// The wrap is handled by concatenating req with itself and masking off the
// bits below ptr; the lowest remaining bit is the winner, folded back into
// the 0..NUM_REQ-1 range.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] masked_s;
    logic                 found_s;

    // Double the request vector and drop everything below the pointer.
    always_comb begin
        dbl_s    = {req, req};
        masked_s = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (i >= int'(ptr)) begin
                masked_s[i] = dbl_s[i];
            end else begin
                masked_s[i] = 1'b0;
            end
        end
    end

    // Lowest surviving bit wins; indices in the upper copy fold back down.
    always_comb begin
        found_s = 1'b0;
        win_idx = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found_s && masked_s[i]) begin
                found_s = 1'b1;
                if (i >= NUM_REQ) begin
                    win_idx = IDX_W'(i - NUM_REQ);
                end else begin
                    win_idx = IDX_W'(i);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot form of the winner, gated by request presence.
    always_comb begin
        any = |req;
        if (any) begin
            win = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        end else begin
            win = '0;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered one-hot grant and valid/ready
// handshake. Priority rotates to the requester after the one just accepted.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        [NUM_REQ] request vector
//   gnt_o        [NUM_REQ] registered one-hot grant (zero when not valid)
//   gnt_valid_o  grant presented
//   gnt_ready_i  downstream accepts the presented grant
//   ptr_o        [IDX_W] current highest-priority index (debug)
// A presented grant is held, ignoring req_i, until accepted. On acceptance
// the pointer advances past the granted index and the pick is re-run in the
// same cycle with that new pointer, giving one grant per cycle when busy.
// -----------------------------------------------------------------------------
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i,
    output logic [IDX_W-1:0]   ptr_o
);

    rr_state_e            state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     gnt_idx_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic                 valid_r;

    logic [IDX_W-1:0]     next_ptr_s;
    logic [IDX_W-1:0]     pick_ptr_s;
    logic [NUM_REQ-1:0]   pick_win_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_any_s;

    // Pointer that takes effect once the current grant is accepted.
    always_comb begin
        next_ptr_s = IDX_W'(wrap_inc(32'(gnt_idx_r), NUM_REQ));
    end

    // While a grant is out, the only pick that matters is the one made on
    // handshake, which must already see the advanced pointer.
    always_comb begin
        if (state_r == GRANT) begin
            pick_ptr_s = next_ptr_s;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_i),
        .ptr     (pick_ptr_s),
        .win     (pick_win_s),
        .win_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Control FSM with pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gnt_idx_r <= '0;
            gnt_r     <= '0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        gnt_r     <= pick_win_s;
                        gnt_idx_r <= pick_idx_s;
                        valid_r   <= 1'b1;
                        state_r   <= GRANT;
                    end else begin
                        gnt_r   <= '0;
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (gnt_ready_i) begin
                        ptr_r <= next_ptr_s;
                        if (pick_any_s) begin
                            gnt_r     <= pick_win_s;
                            gnt_idx_r <= pick_idx_s;
                            valid_r   <= 1'b1;
                            state_r   <= GRANT;
                        end else begin
                            gnt_r   <= '0;
                            valid_r <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    ptr_r     <= '0;
                    gnt_idx_r <= '0;
                    gnt_r     <= '0;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_r;
    assign gnt_valid_o = valid_r;
    assign ptr_o       = ptr_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Directed scenarios plus a randomized run against a behavioural
// round-robin model (ring scan from the pointer) for rr_arbiter, NUM_REQ=8.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic         gnt_ready_i;
    logic [2:0]   ptr_o;

    int n_checks;
    int n_fail;

    rr_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .ptr_o       (ptr_o)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference pick: first requester found walking the ring from p.
    function automatic int scan(input logic [N-1:0] r, input int p);
        int res;
        res = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (r[(p + k) % N]) res = (p + k) % N;
        end
        return res;
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (gnt_o !== 8'h00 || gnt_valid_o !== 1'b0 || ptr_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_init: gnt=%h valid=%b ptr=%0d, expected 00/0/0", gnt_o, gnt_valid_o, ptr_o);
        end
        req_i       = 8'hFF;
        gnt_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (gnt_o !== 8'h02 || gnt_valid_o !== 1'b1 || ptr_o !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_pre: gnt=%h valid=%b ptr=%0d, expected 02/1/1", gnt_o, gnt_valid_o, ptr_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt_o !== 8'h00 || gnt_valid_o !== 1'b0 || ptr_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: gnt=%h valid=%b ptr=%0d, expected 00/0/0", gnt_o, gnt_valid_o, ptr_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_i       = 8'h04;
        gnt_ready_i = 1'b1;
        step();
        n_checks++;
        if (gnt_o !== 8'h04 || gnt_valid_o !== 1'b1 || ptr_o !== 3'd0) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%h valid=%b ptr=%0d, expected 04/1/0", gnt_o, gnt_valid_o, ptr_o);
        end
        req_i = 8'h00;
        step();
        n_checks++;
        if (gnt_o !== 8'h00 || gnt_valid_o !== 1'b0 || ptr_o !== 3'd3) begin
            n_fail++;
            $display("FAIL single_idle: gnt=%h valid=%b ptr=%0d, expected 00/0/3", gnt_o, gnt_valid_o, ptr_o);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp;
        do_reset();
        req_i       = 8'hFF;
        gnt_ready_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step();
            exp = 8'h01 << (k % N);
            n_checks++;
            if (gnt_o !== exp || gnt_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL fairness[%0d]: gnt=%h valid=%b, expected %h/1", k, gnt_o, gnt_valid_o, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_i       = 8'h24;
        gnt_ready_i = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req_i = 8'bx;
            if (k == 3) req_i = 8'h00;
            step();
            n_checks++;
            if (gnt_o !== 8'h04 || gnt_valid_o !== 1'b1 || ptr_o !== 3'd0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: gnt=%h valid=%b ptr=%0d, expected 04/1/0", k, gnt_o, gnt_valid_o, ptr_o);
            end
        end
        req_i       = 8'h24;
        gnt_ready_i = 1'b1;
        step();
        gnt_ready_i = 1'b0;
        n_checks++;
        if (gnt_o !== 8'h20 || gnt_valid_o !== 1'b1 || ptr_o !== 3'd3) begin
            n_fail++;
            $display("FAIL backpressure_release: gnt=%h valid=%b ptr=%0d, expected 20/1/3", gnt_o, gnt_valid_o, ptr_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_i       = 8'h40;
        gnt_ready_i = 1'b1;
        step();
        req_i = 8'h81;
        step();
        n_checks++;
        if (gnt_o !== 8'h80 || ptr_o !== 3'd7) begin
            n_fail++;
            $display("FAIL wrap_top: gnt=%h ptr=%0d, expected 80/7", gnt_o, ptr_o);
        end
        step();
        n_checks++;
        if (gnt_o !== 8'h01 || ptr_o !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: gnt=%h ptr=%0d, expected 01/0", gnt_o, ptr_o);
        end
    endtask

    task automatic test_random();
        int           m_ptr;
        int           m_gidx;
        bit           m_busy;
        logic [N-1:0] held;
        logic [N-1:0] exp_gnt;
        int           waits [N];
        int           max_wait;
        int           dec_idx;
        bit           dec_valid;
        do_reset();
        m_ptr  = 0;
        m_gidx = 0;
        m_busy = 1'b0;
        held   = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 3) == 0) held = held | N'($urandom);
            req_i       = held;
            gnt_ready_i = ($urandom_range(0, 3) != 0);
            // model update for this edge
            if (!m_busy) begin
                if (held != '0) begin
                    m_gidx = scan(held, m_ptr);
                    m_busy = 1'b1;
                end
            end else if (gnt_ready_i) begin
                for (int i = 0; i < N; i++) begin
                    if (held[i] && i != m_gidx) waits[i]++;
                end
                waits[m_gidx] = 0;
                m_ptr = (m_gidx + 1) % N;
                if (held != '0) begin
                    m_gidx = scan(held, m_ptr);
                end else begin
                    m_busy = 1'b0;
                end
                held[(m_ptr + N - 1) % N] = 1'b0;
            end
            step();
            exp_gnt = m_busy ? (8'h01 << m_gidx) : 8'h00;
            dec_valid = 1'b0;
            dec_idx   = 0;
            for (int i = 0; i < N; i++) begin
                if (gnt_o[i]) begin
                    dec_valid = 1'b1;
                    dec_idx   = i;
                end
            end
            max_wait = 0;
            for (int i = 0; i < N; i++) if (waits[i] > max_wait) max_wait = waits[i];
            n_checks++;
            if (gnt_o !== exp_gnt || gnt_valid_o !== m_busy || ptr_o !== 3'(m_ptr)) begin
                n_fail++;
                $display("FAIL random_model[%0d]: gnt=%h valid=%b ptr=%0d, expected %h/%b/%0d", cyc, gnt_o, gnt_valid_o, ptr_o, exp_gnt, m_busy, m_ptr);
            end
            n_checks++;
            if (dec_valid !== gnt_valid_o || (dec_valid && dec_idx != m_gidx)) begin
                n_fail++;
                $display("FAIL random_decode[%0d]: dec_valid=%b idx=%0d, expected %b/%0d", cyc, dec_valid, dec_idx, gnt_valid_o, m_gidx);
            end
            n_checks++;
            if (!$onehot0(gnt_o) || max_wait > N) begin
                n_fail++;
                $display("FAIL random_onehot_starve[%0d]: gnt=%h max_wait=%0d, expected onehot0 and <=%0d", cyc, gnt_o, max_wait, N);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
